// File: rtl/seg7_scan_ctrl_pkg.sv
// seg7_scan_ctrl_pkg: shared segment table, polarity and digit count for the display blocks
package seg7_scan_ctrl_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic SEG_ACTIVE_HIGH = 1'b1;
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble to gfedcba segment lookup
module seg7_hex_decode
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_ACTIVE_HIGH ? SEG_TABLE[nib] : ~SEG_TABLE[nib];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: latches a 32-bit word and time-multiplexes it onto an 8-digit seven-segment array
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int DIV_CNT = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int CNT_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [31:0]           wdata,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  disp_en,
  input  logic                  lz_en,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [31:0]           shown
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(DIV_CNT - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  logic [31:0] data_reg;
  logic [NUM_DIGITS-1:0] dp_reg;
  logic [CNT_W-1:0] slot_cnt;
  logic [IDX_W-1:0] scan_idx;
  logic [NUM_DIGITS-1:0] supp;
  logic [6:0] hex;
  logic lit;
  assign shown = data_reg;
  // a digit is suppressed when it and every digit to its left are zero; digit 0 always shows
  always_comb begin
    supp = '0;
    for (int i = 1; i < NUM_DIGITS; i++) supp[i] = lz_en && ((data_reg >> (4 * i)) == 32'd0);
  end
  seg7_hex_decode u_dec (
    .nib(data_reg[{scan_idx, 2'b00} +: 4]),
    .seg(hex)
  );
  assign lit = disp_en && (slot_cnt >= BLANK_END) && !supp[scan_idx];
  // write latch; independent of the scan so writes never shift digit timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      dp_reg <= '0;
    end else if (wr_en) begin
      data_reg <= wdata;
      dp_reg <= dp_in;
    end
  end
  // slot counter and digit index keep running even while the display is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      scan_idx <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      scan_idx <= scan_idx + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end
  // registered pin drive; the decimal point follows its digit's suppression
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an <= '0;
      seg <= '0;
    end else begin
      an <= lit ? NUM_DIGITS'(1) << scan_idx : '0;
      seg <= lit ? {dp_reg[scan_idx], hex} : '0;
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed and random stimulus checked against a time-based display model
module tb_seg7_scan_ctrl;
  localparam int DIV = 4;
  localparam int BLANK = 1;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [7:0] dp_in = '0;
  logic disp_en = 1'b1;
  logic lz_en = 1'b0;
  logic [7:0] seg;
  logic [7:0] an;
  logic [31:0] shown;
  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [31:0] mdata = '0;
  logic [7:0] mdp = '0;
  logic [7:0] ea, es;
  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_scan_ctrl #(.DIV_CNT(DIV), .BLANK_CYCLES(BLANK), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .dp_in(dp_in),
    .disp_en(disp_en), .lz_en(lz_en), .seg(seg), .an(an), .shown(shown)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // model: n edges since reset fix the slot position; digit shown is nibble (n/DIV)%8 of the word latched before this edge
  task automatic step(input string tag);
    int idx, pos;
    logic [31:0] rest;
    bit on;
    @(posedge clk);
    if (rst) begin
      n = 0; mdata = '0; mdp = '0; ea = '0; es = '0;
    end else begin
      idx = (n / DIV) % 8;
      pos = n % DIV;
      rest = mdata >> (4 * idx);
      on = disp_en && pos >= BLANK && !(lz_en && idx != 0 && rest == 0);
      ea = on ? 8'(1 << idx) : 8'h00;
      es = on ? {mdp[idx], hex_tbl[rest[3:0]]} : 8'h00;
      if (wr_en) begin
        mdata = wdata;
        mdp = dp_in;
      end
      n++;
    end
    #1;
    chk({tag, ".an"}, {24'd0, an}, {24'd0, ea});
    chk({tag, ".seg"}, {24'd0, seg}, {24'd0, es});
    chk({tag, ".shown"}, shown, mdata);
  endtask

  task automatic write(input logic [31:0] d, input logic [7:0] dp, input string tag);
    wr_en = 1'b1; wdata = d; dp_in = dp;
    step(tag);
    wr_en = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("async_rst.an", {24'd0, an}, 32'd0);
    chk("async_rst.seg", {24'd0, seg}, 32'd0);
    chk("async_rst.shown", shown, 32'd0);
    repeat (3) step("in_rst");
    rst = 1'b0;
    repeat (36) step("idle_scan");
    write(32'h1234ABCD, 8'h01, "wr1234");
    repeat (40) step("show1234");
    lz_en = 1'b1;
    write(32'h000000A5, 8'hFF, "wrA5");
    repeat (40) step("lzA5");
    write(32'h0, 8'hFF, "wr0");
    repeat (36) step("lz0");
    lz_en = 1'b0;
    write(32'h00004000, 8'h00, "wr4000");
    for (int k = 0; k < 40 && !((n / DIV) % 8 == 3 && n % DIV == 1); k++) step("seek3");
    write(32'h0000F000, 8'h00, "wrF000");
    repeat (12) step("afterF");
    for (int k = 0; k < 8 && n % DIV != 2; k++) step("seek_mid");
    disp_en = 1'b0;
    repeat (5) step("disp_off");
    disp_en = 1'b1;
    repeat (20) step("disp_on");
    write(32'h76543210, 8'hAA, "wr7654");
    for (int k = 0; k < 40 && ea != 8'h10; k++) step("seek_an10");
    chk("seek_an10.found", {24'd0, ea}, 32'h10);
    #2 rst = 1'b1;
    wr_en = 1'b1; wdata = 32'hDEADBEEF; dp_in = 8'hFF;
    #1;
    n = 0; mdata = '0; mdp = '0;
    chk("mid_rst.an", {24'd0, an}, 32'd0);
    chk("mid_rst.seg", {24'd0, seg}, 32'd0);
    chk("mid_rst.shown", shown, 32'd0);
    step("rst_with_wr");
    wr_en = 1'b0;
    rst = 1'b0;
    repeat (10) step("post_rst");
    for (int k = 0; k < 600; k++) begin
      wr_en = ($urandom_range(0, 7) == 0);
      wdata = $urandom >> ($urandom_range(0, 8) * 4);
      dp_in = 8'($urandom);
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      disp_en = ($urandom_range(0, 9) != 0);
      step("random");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Downstream consumer of the CPU's 32-bit digital output, i.e. the MemOrIO write_data qualified by DigitalCtrl.
- Latches the word on a write strobe and drives the 8-digit seven-segment array by time-multiplexing: one digit active per scan slot, hex-decoded.
- Adds inter-digit ghost blanking, optional leading-zero suppression and per-digit decimal points.
- Sits between the CPU top and the board's segment/digit-enable pins.

Parameters:
- DIV_CNT, 100000, cpu_clk cycles per digit slot (≥2).
- BLANK_CYCLES, 1000, cycles at the start of each slot with all digit enables off (< DIV_CNT).
- CNT_W, 17, width of the slot counter (≥ clog2(DIV_CNT)).

Ports:
- clk  in  1  CPU clock (cpu_clk).
- rst  in  1  asynchronous reset, active-high.
- wr_en  in  1  write strobe; CPU drives IOWrite & DigitalCtrl.
- wdata  in  32  word to display; nibble i shown on digit i, digit 0 rightmost.
- dp_in  in  8  per-digit decimal point, latched with wdata.
- disp_en  in  1  1 = display on, 0 = all digit enables off.
- lz_en  in  1  1 = suppress leading zeros.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-high, registered.
- an  out  8  digit enables, one-hot or zero, active-high, registered.
- shown  out  32  currently latched word, for debug/readback.

Behaviour:
- Reset (asynchronous, immediate): data_reg = 0, dp_reg = 0, slot_cnt = 0, scan_idx = 0, seg = 8'h00, an = 8'h00, shown = 0.
- Write:
  - wr_en = 1 at a rising edge loads data_reg ← wdata and dp_reg ← dp_in.
  - shown = data_reg, so it is valid one cycle after the write edge.
  - wr_en held high reloads every cycle; last value wins.
  - Writes never disturb slot_cnt or scan_idx.
- Scan counter:
  - slot_cnt counts 0..DIV_CNT-1 every cycle.
  - At DIV_CNT-1: slot_cnt ← 0 and scan_idx ← scan_idx+1 mod 8 (7 wraps to 0).
  - Counting continues when disp_en = 0, so the scan phase is unaffected by enable toggling.
- Digit suppression (combinational, from data_reg):
  - supp[i] = lz_en & (i≠0) & (data_reg[31:4i] == 0).
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - The decimal point of a suppressed digit is also hidden.
- Output register (updated every cycle from the current slot_cnt, scan_idx and data_reg, so one cycle of output latency):
  - an ← (disp_en & slot_cnt ≥ BLANK_CYCLES & !supp[scan_idx]) ? (8'b1 << scan_idx) : 8'h00.
  - seg ← {dp_reg[scan_idx], hex7(data_reg[4·scan_idx +: 4])} when an is enabled; otherwise seg ← 8'h00.
- Latency:
  - A write affecting the currently active digit reaches seg two edges after the wr_en edge: one edge to latch, one edge to register the output.
  - an never has more than one bit set.
  - The slot boundary produces at least BLANK_CYCLES cycles of an = 0 between digits.
- Hex encoding (gfedcba):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Reset mid-slot: outputs clear immediately; scanning restarts at digit 0, slot_cnt 0.
- rst and wr_en together: reset dominates and the write is lost.

Decomposition:
- Shared package: the 16-entry segment constant table, the active-high polarity constant, and the digit count (8).
- One sub-module, seg7_hex_decode: pure combinational nibble→7-bit lookup, reused by any future LED/segment block.
- Counter, latch and suppression logic stay in seg7_scan_ctrl.

Test Plan (DIV_CNT=4, BLANK_CYCLES=1, disp_en=1, lz_en=0 unless stated):
- Release reset, no write -> an=00 during the blank cycle, then one-hot 01,02,…,80 for 3 cycles each, wrapping to 01; seg=3F whenever an≠0.
- Write 32'h1234ABCD, dp_in=8'h01 -> shown=1234ABCD next cycle; digit0 seg=DE (0x5E|dp), digit1 seg=39, digit7 seg=06; digit with an=02 never displays dp.
- lz_en=1, write 32'h0000_00A5 -> an only ever 01 or 02 (seg 6D, 77); slots 2–7 keep an=00; write 0 -> only digit0 shows 3F.
- Write on the cycle scan_idx=3 is active with wdata nibble3 changing 4→F -> seg changes 66→71 exactly two edges after the wr_en edge; scan timing unchanged.
- disp_en toggled low for 5 cycles mid-scan -> an=00, seg=00 during that window; afterwards scan_idx matches an uninterrupted counter.
- Assert rst mid-slot with an=10 -> an, seg, shown drop to 0 without waiting for a clock edge; after release, digit0 active again after BLANK_CYCLES+1 cycles.
